// File: rtl/calc_display.sv
// 8-bit binary to decimal display driver: sequential double-dabble conversion
// feeding a 3-digit multiplexed common-anode 7-segment scan.
module calc_display #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter bit          BLANK_LZ    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] dataIn,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CNT_W   = $clog2(REFRESH_DIV);
    localparam int unsigned SHR_W   = 20;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] CONVERT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [7:0]       last_q, last_d;
    logic [SHR_W-1:0] shreg_q, shreg_d, adj;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic [3:0]       hun_q, hun_d, ten_q, ten_d, one_q, one_d;
    logic             busy_d, done_d;

    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       idx_q;
    logic [3:0]       digit;
    logic             blank;
    logic [6:0]       seg_d;
    logic [3:0]       an_d;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = 7'b1111111;
        endcase
    endfunction

    // Add-3 correction on every BCD nibble that would overflow on the next shift
    always_comb begin
        adj = shreg_q;
        for (int i = 0; i < 3; i++) begin
            if (shreg_q[8 + i*4 +: 4] >= 4'd5)
                adj[8 + i*4 +: 4] = shreg_q[8 + i*4 +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        hun_d    = hun_q;
        ten_d    = ten_q;
        one_d    = one_q;
        busy_d   = busy;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (dataIn != last_q) begin
                    last_d   = dataIn;
                    shreg_d  = {12'b0, dataIn};
                    bitcnt_d = 3'd0;
                    state_d  = CONVERT;
                    busy_d   = 1'b1;
                end
            end
            CONVERT: begin
                shreg_d  = adj << 1;
                bitcnt_d = bitcnt_q + 3'd1;
                if (bitcnt_q == 3'd7) begin
                    hun_d   = shreg_d[19:16];
                    ten_d   = shreg_d[15:12];
                    one_d   = shreg_d[11:8];
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q   <= '0;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            hun_q    <= '0;
            ten_q    <= '0;
            one_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            last_q   <= last_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            hun_q    <= hun_d;
            ten_q    <= ten_d;
            one_q    <= one_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

    // Free-running scan timebase, independent of conversion
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= 2'd0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_q <= '0;
            idx_q <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        digit = one_q;
        blank = 1'b0;
        an_d  = 4'b1111;
        case (idx_q)
            2'd0: begin digit = one_q; an_d = 4'b1110; end
            2'd1: begin
                digit = ten_q;
                an_d  = 4'b1101;
                blank = BLANK_LZ && (hun_q == 4'd0) && (ten_q == 4'd0);
            end
            2'd2: begin
                digit = hun_q;
                an_d  = 4'b1011;
                blank = BLANK_LZ && (hun_q == 4'd0);
            end
            default: blank = 1'b1;
        endcase
        seg_d = seg_code(digit);
        if (blank) begin
            an_d  = 4'b1111;
            seg_d = 7'b1111111;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= 4'b1110;
            seg <= 7'b1000000;
        end else begin
            an  <= an_d;
            seg <= seg_d;
        end
    end

endmodule

// File: tb/tb_calc_display.sv
// Randomized bench for calc_display: a cycle-level arithmetic model predicts
// conversion timing and the scanned display for blanking and non-blanking copies.
module tb_calc_display;

    localparam int unsigned DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'd0;
    logic [6:0] seg, seg_nb;
    logic [3:0] an, an_nb;
    logic       busy, done, busy_nb, done_nb;

    int checks = 0;
    int errors = 0;

    logic [6:0] codes [10];

    // reference model state
    int m_last, m_val, m_shown, m_rem, m_k, m_disp_val, m_disp_idx;
    bit m_busy, m_done;

    calc_display #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst(rst), .dataIn(data_in),
        .seg(seg), .an(an), .busy(busy), .done(done)
    );

    calc_display #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .dataIn(data_in),
        .seg(seg_nb), .an(an_nb), .busy(busy_nb), .done(done_nb)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] exp_disp(input int val, input int idx, input bit blank_lz);
        int h, t, o, d;
        bit bl;
        h  = val / 100;
        t  = (val / 10) % 10;
        o  = val % 10;
        d  = (idx == 0) ? o : (idx == 1) ? t : h;
        bl = blank_lz && ((idx == 2 && h == 0) || (idx == 1 && h == 0 && t == 0));
        if (bl) return {4'b1111, 7'b1111111};
        return {~(4'd1 << idx), codes[d]};
    endfunction

    // Model: a capture starts 8 edges of conversion; display follows scan time since reset
    always @(posedge clk) begin
        if (rst) begin
            m_last = 0; m_val = 0; m_shown = 0; m_rem = 0; m_k = 0;
            m_busy = 1'b0; m_done = 1'b0; m_disp_val = 0; m_disp_idx = 0;
        end else begin
            m_disp_val = m_shown;
            m_disp_idx = (m_k / DIV) % 3;
            m_k++;
            m_done = 1'b0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_shown = m_val;
                    m_done  = 1'b1;
                    m_busy  = 1'b0;
                end
            end else if (int'(data_in) != m_last) begin
                m_last = int'(data_in);
                m_val  = int'(data_in);
                m_rem  = 8;
                m_busy = 1'b1;
            end
        end
    end

    task automatic test_reset();
        int busy_cnt = 0, done_cnt = 0;
        rst = 1'b1; data_in = 8'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            busy_cnt += int'(busy); done_cnt += int'(done);
            checks++;
            if ({busy, done, an, seg} !== {m_busy, m_done, exp_disp(m_disp_val, m_disp_idx, 1'b1)}) begin
                errors++; $display("FAIL reset cyc%0d got %b exp %b", i, {busy, done, an, seg}, {m_busy, m_done, exp_disp(m_disp_val, m_disp_idx, 1'b1)});
            end
        end
        checks++;
        if (busy_cnt !== 0 || done_cnt !== 0) begin
            errors++; $display("FAIL reset_idle busy=%0d done=%0d exp 0/0", busy_cnt, done_cnt);
        end
    endtask

    task automatic test_convert(input logic [7:0] v, input logic [6:0] e0, input logic [6:0] e1,
                                input logic [6:0] e2);
        int busy_cnt = 0, done_cnt = 0;
        logic [6:0] s0 = 7'bx, s1 = 7'bx, s2 = 7'bx;
        data_in = v;
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            busy_cnt += int'(busy); done_cnt += int'(done);
            if (i >= 14) begin
                if (an == 4'b1110) s0 = seg;
                if (an == 4'b1101) s1 = seg;
                if (an == 4'b1011) s2 = seg;
            end
            checks++;
            if ({busy, done, an, seg} !== {m_busy, m_done, exp_disp(m_disp_val, m_disp_idx, 1'b1)}) begin
                errors++; $display("FAIL convert_%0d cyc%0d got %b exp %b", v, i, {busy, done, an, seg}, {m_busy, m_done, exp_disp(m_disp_val, m_disp_idx, 1'b1)});
            end
        end
        checks++;
        if (busy_cnt !== 8 || done_cnt !== 1) begin
            errors++; $display("FAIL convert_%0d_timing busy=%0d done=%0d exp 8/1", v, busy_cnt, done_cnt);
        end
        checks++;
        if ({s0, s1, s2} !== {e0, e1, e2}) begin
            errors++; $display("FAIL convert_%0d_slots got %b %b %b exp %b %b %b", v, s0, s1, s2, e0, e1, e2);
        end
    endtask

    task automatic test_mid_change();
        int done_cnt = 0;
        data_in = 8'd100;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            done_cnt += int'(done);
            if (i == 2) data_in = 8'd17;
            checks++;
            if ({busy, done, an, seg} !== {m_busy, m_done, exp_disp(m_disp_val, m_disp_idx, 1'b1)}) begin
                errors++; $display("FAIL mid_change cyc%0d got %b exp %b", i, {busy, done, an, seg}, {m_busy, m_done, exp_disp(m_disp_val, m_disp_idx, 1'b1)});
            end
        end
        checks++;
        if (done_cnt !== 2 || m_shown !== 17) begin
            errors++; $display("FAIL mid_change_count done=%0d exp 2", done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int done_cnt = 0;
        data_in = 8'd200;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, an, seg} !== {1'b0, 1'b0, 4'b1110, 7'b1000000}) begin
            errors++; $display("FAIL reset_mid_state got %b exp 0011101000000", {busy, done, an, seg});
        end
        rst = 1'b0;
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            done_cnt += int'(done);
            checks++;
            if ({busy, done, an, seg} !== {m_busy, m_done, exp_disp(m_disp_val, m_disp_idx, 1'b1)}) begin
                errors++; $display("FAIL reset_mid cyc%0d got %b exp %b", i, {busy, done, an, seg}, {m_busy, m_done, exp_disp(m_disp_val, m_disp_idx, 1'b1)});
            end
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++; $display("FAIL reset_mid_done done=%0d exp 1", done_cnt);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            data_in = 8'($urandom_range(0, 255));
            repeat ($urandom_range(1, 14)) begin
                @(negedge clk);
                checks++;
                if ({busy, done, an, seg, busy_nb, done_nb, an_nb, seg_nb} !==
                    {m_busy, m_done, exp_disp(m_disp_val, m_disp_idx, 1'b1),
                     m_busy, m_done, exp_disp(m_disp_val, m_disp_idx, 1'b0)}) begin
                    errors++; $display("FAIL random val=%0d got %b/%b exp %b/%b", m_disp_val, {busy, done, an, seg}, {an_nb, seg_nb}, {m_busy, m_done, exp_disp(m_disp_val, m_disp_idx, 1'b1)}, exp_disp(m_disp_val, m_disp_idx, 1'b0));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit prev_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            data_in = 8'((m_last + 1 + int'($urandom_range(0, 254))) % 256);
            @(negedge clk);
            if (prev_done) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++; $display("FAIL back_to_back_restart busy=%b exp 1", busy);
                end
            end
            prev_done = done;
            checks++;
            if ({busy, done, an, seg} !== {m_busy, m_done, exp_disp(m_disp_val, m_disp_idx, 1'b1)}) begin
                errors++; $display("FAIL back_to_back cyc%0d got %b exp %b", i, {busy, done, an, seg}, {m_busy, m_done, exp_disp(m_disp_val, m_disp_idx, 1'b1)});
            end
        end
    endtask

    task automatic test_no_blank();
        logic [6:0] s0 = 7'bx, s1 = 7'bx, s2 = 7'bx;
        data_in = 8'd5;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i >= 26) begin
                if (an_nb == 4'b1110) s0 = seg_nb;
                if (an_nb == 4'b1101) s1 = seg_nb;
                if (an_nb == 4'b1011) s2 = seg_nb;
            end
            checks++;
            if ({busy_nb, done_nb, an_nb, seg_nb} !== {m_busy, m_done, exp_disp(m_disp_val, m_disp_idx, 1'b0)}) begin
                errors++; $display("FAIL no_blank cyc%0d got %b exp %b", i, {busy_nb, done_nb, an_nb, seg_nb}, {m_busy, m_done, exp_disp(m_disp_val, m_disp_idx, 1'b0)});
            end
        end
        checks++;
        if ({s0, s1, s2} !== {7'b0010010, 7'b1000000, 7'b1000000}) begin
            errors++; $display("FAIL no_blank_slots got %b %b %b exp 0010010 1000000 1000000", s0, s1, s2);
        end
    endtask

    initial begin
        codes[0] = 7'b1000000; codes[1] = 7'b1111001; codes[2] = 7'b0100100;
        codes[3] = 7'b0110000; codes[4] = 7'b0011001; codes[5] = 7'b0010010;
        codes[6] = 7'b0000010; codes[7] = 7'b1111000; codes[8] = 7'b0000000;
        codes[9] = 7'b0010000;
        test_reset();
        test_convert(8'd255, 7'b0010010, 7'b0010010, 7'b0100100);
        test_convert(8'd7, 7'b1111000, 7'bx, 7'bx);
        test_mid_change();
        test_reset_mid();
        test_random();
        test_back_to_back();
        test_no_blank();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
